// File: rtl/conv_25_feeder.sv
// conv_25_feeder: runs one 5x5 convolution job at a time. It clears the array,
// loads 25 weights, streams num_pix pixels, buffers the array results in a FIFO
// and signals done once every result has been handed off.
// Optional feature macro: CONV_FEEDER_RELU_EN (clamps negative results to zero
// before they enter the result FIFO).

`ifndef QDATA_BUS_WIDTH
`define QDATA_BUS_WIDTH 16
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module conv_25_feeder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ANS_LAT    = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_pix,
    input  logic                        wt_valid,
    output logic                        wt_ready,
    input  logic [`QDATA_BUS_WIDTH-1:0] wt_data,
    input  logic                        px_valid,
    output logic                        px_ready,
    input  logic [`QDATA_BUS_WIDTH-1:0] px_data,
    output logic [`QDATA_BUS_WIDTH-1:0] conv_w_in,
    output logic [`QDATA_BUS_WIDTH-1:0] conv_d_in,
    output logic                        conv_w_en,
    output logic                        conv_z_en,
    input  logic [`DATA_BUS_WIDTH-1:0]  conv_ans,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [`DATA_BUS_WIDTH-1:0]  res_data,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned QW       = `QDATA_BUS_WIDTH;
    localparam int unsigned DW       = `DATA_BUS_WIDTH;
    localparam int unsigned NUM_WT   = 25;
    localparam int unsigned WT_CNT_W = 5;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAT_W    = $clog2(ANS_LAT + 1);
    localparam int unsigned OCC_W    = $clog2(FIFO_DEPTH + ANS_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_W,
        STREAM,
        DRAIN
    } state_t;

    state_t              state;
    logic [WT_CNT_W-1:0] wt_cnt;
    logic [CNT_W-1:0]    remaining;

    logic [ANS_LAT-1:0]  tags;
    logic [LAT_W-1:0]    in_flight;

    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [FCNT_W-1:0]   fifo_count;

    logic                wt_fire;
    logic                px_fire;
    logic                push;
    logic                pop;
    logic [DW-1:0]       push_data;
    logic [OCC_W-1:0]    occupancy;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes and stream-side decodes; pixel admission reserves a FIFO slot per sample in flight
    assign wt_fire   = wt_valid & wt_ready;
    assign px_fire   = px_valid & px_ready;
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(in_flight);
    assign wt_ready  = (state == LOAD_W);
    assign px_ready  = (state == STREAM) && (remaining != '0) && (occupancy < OCC_W'(FIFO_DEPTH));
    assign busy      = (state != IDLE);
    assign conv_z_en = (state == CLEAR);
    assign conv_w_en = wt_fire;
    assign conv_w_in = wt_fire ? wt_data : QW'(0);
    assign conv_d_in = px_fire ? px_data : QW'(0);
    assign push      = tags[ANS_LAT-1];
    assign pop       = res_valid & res_ready;
    assign res_valid = (fifo_count != '0);
    assign res_data  = res_valid ? mem[rd_ptr] : DW'(0);

`ifdef CONV_FEEDER_RELU_EN
    assign push_data = conv_ans[DW-1] ? DW'(0) : conv_ans;
`else
    assign push_data = conv_ans;
`endif

    // Job sequencer: clear, weight load, pixel stream, drain, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wt_cnt    <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_pix == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= num_pix;
                            state     <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    wt_cnt <= '0;
                    state  <= LOAD_W;
                end
                LOAD_W: begin
                    if (wt_fire) begin
                        if (wt_cnt == WT_CNT_W'(NUM_WT - 1)) begin
                            wt_cnt <= '0;
                            state  <= STREAM;
                        end else begin
                            wt_cnt <= wt_cnt + WT_CNT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (px_fire) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((in_flight == '0) && (fifo_count == '0)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid tags follow each sample through the array latency
    always_ff @(posedge clk) begin
        if (rst) begin
            tags      <= '0;
            in_flight <= '0;
        end else begin
            tags[0] <= px_fire;
            for (int i = 1; i < int'(ANS_LAT); i++) begin
                tags[i] <= tags[i-1];
            end
            case ({px_fire, push})
                2'b10:   in_flight <= in_flight + LAT_W'(1);
                2'b01:   in_flight <= in_flight - LAT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Result FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_conv_25_feeder.sv
// tb_conv_25_feeder: drives jobs into conv_25_feeder with a behavioural 25-tap
// array stand-in, predicts every result from the accepted weights and pixels,
// and checks results in a decoupled scoreboard monitor.
// Honours CONV_FEEDER_RELU_EN when it is defined for the build.

module tb_conv_25_feeder;

    localparam int QW = 16;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NT = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_pix;
    logic          wt_valid;
    logic          wt_ready;
    logic [QW-1:0] wt_data;
    logic          px_valid;
    logic          px_ready;
    logic [QW-1:0] px_data;
    logic [QW-1:0] conv_w_in;
    logic [QW-1:0] conv_d_in;
    logic          conv_w_en;
    logic          conv_z_en;
    logic [DW-1:0] conv_ans;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    int wts[NT];
    int pix[64];

    int w_acc    = 0;
    int p_acc    = 0;
    int done_cnt = 0;
    int wen_cnt  = 0;
    int zen_cnt  = 0;
    int res_cnt  = 0;

    int            wq[$];
    int            hist[NT];
    logic [DW-1:0] expq[$];
    logic [DW-1:0] got[$];

    int wsh[NT];
    int dsh[NT];

    always #5 clk = ~clk;

    conv_25_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pix   (num_pix),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .wt_data   (wt_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .conv_w_in (conv_w_in),
        .conv_d_in (conv_d_in),
        .conv_w_en (conv_w_en),
        .conv_z_en (conv_z_en),
        .conv_ans  (conv_ans),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Stand-in for the convolution array: weight and sample shift chains, one-cycle answer
    always @(posedge clk) begin
        if (conv_w_en) begin
            for (int i = NT - 1; i > 0; i--) wsh[i] <= wsh[i-1];
            wsh[0] <= int'($signed(conv_w_in));
        end
        for (int i = NT - 1; i > 0; i--) dsh[i] <= conv_z_en ? 0 : dsh[i-1];
        dsh[0] <= conv_z_en ? 0 : int'($signed(conv_d_in));
    end

    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < NT; i++) s += wsh[i] * dsh[i];
        conv_ans = DW'(s);
    end

    // Reference: sample history from accepted pixels, expected result queued per pixel
    always begin
        int e;
        int hv;
        @(negedge clk);
        hv = (px_valid && px_ready) ? int'($signed(px_data)) : 0;
        for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = hv;
        if (wt_valid && wt_ready) begin
            wq.push_back(int'($signed(wt_data)));
            w_acc++;
        end
        if (conv_w_en) wen_cnt++;
        if (conv_z_en) zen_cnt++;
        if (done) done_cnt++;
        if (px_valid && px_ready) begin
            p_acc++;
            e = 0;
            if (wq.size() >= NT) begin
                for (int j = 0; j < NT; j++) e += wq[wq.size() - 1 - j] * hist[j];
            end
`ifdef CONV_FEEDER_RELU_EN
            if (e < 0) e = 0;
`endif
            expq.push_back(DW'(e));
        end
    end

    // Monitor: pops the scoreboard on every result handshake
    always begin
        logic [DW-1:0] e;
        @(negedge clk);
        if (rst) begin
            expq.delete();
        end else if (res_valid && res_ready) begin
            got.push_back(res_data);
            res_cnt++;
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL res_unexpected: got %0d, required no result", $signed(res_data));
            end else begin
                e = expq.pop_front();
                check("res_data", longint'($signed(res_data)), longint'($signed(e)));
            end
        end
    end

    function automatic longint val(input int idx);
        if (idx < got.size()) return longint'($signed(got[idx]));
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      longint'(busy),      0);
        check({tag, "_done"},      longint'(done),      0);
        check({tag, "_wt_ready"},  longint'(wt_ready),  0);
        check({tag, "_px_ready"},  longint'(px_ready),  0);
        check({tag, "_res_valid"}, longint'(res_valid), 0);
        check({tag, "_conv_w_en"}, longint'(conv_w_en), 0);
        check({tag, "_conv_z_en"}, longint'(conv_z_en), 0);
        check({tag, "_conv_w_in"}, longint'(conv_w_in), 0);
        check({tag, "_conv_d_in"}, longint'(conv_d_in), 0);
        check({tag, "_res_data"},  longint'(res_data),  0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NT; i++) wts[i] = int'($urandom_range(0, 16)) - 8;
        for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 400)) - 200;
    endtask

    // One full job. wmode: 0 steady, 1 toggling, 2 random weights valid.
    // pmode: 0 steady, 1 random pixel valid. rmode: 0 ready, 1 random, 2 held low then released.
    task automatic run_job(input int n, input int wmode, input int pmode, input int rmode);
        int w0, p0, d0, e0, z0, r0, cyc, wa, pa, early;
        w0 = w_acc; p0 = p_acc; d0 = done_cnt; e0 = wen_cnt; z0 = zen_cnt; r0 = res_cnt;
        early = 0;
        num_pix = CW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("job_busy", longint'(busy), 1);
        check("job_z_en", longint'(conv_z_en), 1);
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            wa = w_acc - w0;
            pa = p_acc - p0;
            if (pa > 0 && wa < NT) early++;
            wt_valid  = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            wt_data   = QW'(wts[wa % NT]);
            px_valid  = (pa < n) && (pmode == 0 || $urandom_range(0, 3) != 0);
            px_data   = QW'(pix[pa % 64]);
            res_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 2) != 0) : (cyc >= 90);
            if (rmode == 2 && cyc == 89) begin
                check("stall_px_count", pa, 8);
                check("stall_px_ready", longint'(px_ready), 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        wt_valid = 1'b0;
        px_valid = 1'b0;
        res_ready = 1'b1;
        check("job_done_seen",   done_cnt - d0, 1);
        check("job_wt_count",    w_acc - w0, NT);
        check("job_px_count",    p_acc - p0, n);
        check("job_w_en_pulses", wen_cnt - e0, NT);
        check("job_z_en_pulses", zen_cnt - z0, 1);
        check("job_results",     res_cnt - r0, n);
        check("job_early_px",    early, 0);
        check("job_busy_end",    longint'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("job_single_done", done_cnt - d0, 1);
        check("job_exp_empty",   expq.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, neg, d0, w0, p0, cyc;
        rst = 1'b1; start = 1'b0; num_pix = '0;
        wt_valid = 1'b0; wt_data = '0; px_valid = 1'b0; px_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones weights over pixels 1..30: running then windowed sums
        for (int i = 0; i < NT; i++) wts[i] = 1;
        for (int i = 0; i < 64; i++) pix[i] = i + 1;
        r0 = res_cnt;
        run_job(30, 0, 0, 0);
        check("sum_first",  val(r0),      1);
        check("sum_second", val(r0 + 1),  3);
        check("sum_25th",   val(r0 + 24), 325);
        check("sum_last",   val(r0 + 29), 450);

        // Same job with the result side stalled, then released
        run_job(30, 0, 0, 2);

        // Zero-length job
        d0 = done_cnt; w0 = w_acc; p0 = p_acc;
        wt_valid = 1'b1; px_valid = 1'b1; num_pix = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done",     longint'(done),     1);
        check("zero_busy",     longint'(busy),     0);
        check("zero_wt_ready", longint'(wt_ready), 0);
        @(posedge clk); #1;
        check("zero_done_width", longint'(done), 0);
        check("zero_busy_after", longint'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        wt_valid = 1'b0; px_valid = 1'b0;
        check("zero_no_wt",   w_acc - w0, 0);
        check("zero_no_px",   p_acc - p0, 0);
        check("zero_one_done", done_cnt - d0, 1);

        // Abort during weight load, then a clean job
        fill_random();
        d0 = done_cnt; w0 = w_acc;
        num_pix = CW'(20); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wt_valid = 1'b1; px_valid = 1'b1; res_ready = 1'b1;
        cyc = 0;
        while (w_acc - w0 < 10 && cyc < 200) begin
            wt_data = QW'(wts[(w_acc - w0) % NT]);
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_wt_reached", longint'(w_acc - w0 >= 10), 1);
        rst = 1'b1; wt_data = 16'h1234; px_data = 16'h0055;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst = 1'b0; wt_valid = 1'b0; px_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done", done_cnt - d0, 0);
        fill_random();
        run_job(20, 2, 1, 1);

        // Alternating -5/+5 pixels with all-ones weights
        for (int i = 0; i < NT; i++) wts[i] = 1;
        for (int i = 0; i < 64; i++) pix[i] = (i % 2 == 0) ? -5 : 5;
        r0 = res_cnt;
        run_job(30, 0, 0, 0);
        neg = 0;
        for (int i = r0; i < got.size(); i++) if (got[i][DW-1]) neg++;
`ifdef CONV_FEEDER_RELU_EN
        check("relu_negatives", neg, 0);
`else
        check("pass_negatives", neg, 15);
`endif

        // Toggling weight valid
        fill_random();
        run_job(12, 1, 1, 1);

        // Single-pixel job
        fill_random();
        run_job(1, 0, 0, 1);

        // Randomised jobs
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_job(int'($urandom_range(1, 40)), 2, 1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv_25_feeder.md
CONV_25_FEEDER -- requirements
Module: conv_25_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: result FIFO entries; legal range 4..64.
REQ-002 Parameter ANS_LAT, default 1: cycles from a sample on conv_d_in to its result on conv_ans.
REQ-003 Parameter CNT_W, default 16: width of the pixel counter.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin job; sampled only in IDLE.
REQ-007 num_pix  in  CNT_W  pixels in the job; latched on start.
REQ-008 wt_valid / wt_ready  in / out  1  weight stream handshake.
REQ-009 wt_data  in  `QDATA_BUS_WIDTH  weight value.
REQ-010 px_valid / px_ready  in / out  1  pixel stream handshake.
REQ-011 px_data  in  `QDATA_BUS_WIDTH  pixel value.
REQ-012 conv_w_in, conv_d_in  out  `QDATA_BUS_WIDTH  weight and sample to conv array.
REQ-013 conv_w_en, conv_z_en  out  1  weight shift enable and accumulator clear to conv array.
REQ-014 conv_ans  in  `DATA_BUS_WIDTH  array result.
REQ-015 res_valid / res_ready  out / in  1  result stream handshake.
REQ-016 res_data  out  `DATA_BUS_WIDTH  result value.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on job completion.

Function
REQ-019 States SHALL be IDLE, CLEAR, LOAD_W, STREAM, DRAIN; one job at a time.
REQ-020 IDLE->CLEAR on start=1 with num_pix!=0; start with num_pix=0 -> stay IDLE, pulse done next cycle.
REQ-021 CLEAR lasts exactly 1 cycle with conv_z_en=1, then LOAD_W.
REQ-022 LOAD_W: wt_ready=1; each wt_valid&wt_ready cycle drives conv_w_in=wt_data, conv_w_en=1 in the same cycle; conv_w_en=0 otherwise.
REQ-023 After exactly 25 accepted weights -> STREAM; weights are forwarded in acceptance order.
REQ-024 STREAM: array advances every cycle; an accepted pixel drives conv_d_in=px_data, otherwise conv_d_in=0 (zero sample, no result generated).
REQ-025 Each sample carries a valid tag through an ANS_LAT-deep shift register; tag=1 only for accepted pixels.
REQ-026 When the tag exits with 1, conv_ans SHALL be written into the result FIFO in that cycle.
REQ-027 px_ready = (state==STREAM) & (remaining>0) & (fifo_count + tags_in_flight < FIFO_DEPTH); FIFO SHALL never overflow.
REQ-028 After the num_pix-th accepted pixel -> DRAIN; DRAIN continues zero samples until no tag in flight and FIFO empty, then done pulse, -> IDLE.
REQ-029 res_valid = FIFO non-empty; res_data = FIFO head; pop on res_valid&res_ready; push and pop in the same cycle SHALL both succeed.
REQ-030 Exactly num_pix results per job, in pixel order; no results are dropped or duplicated under any res_ready pattern.
REQ-031 conv_z_en SHALL be 0 outside CLEAR; start outside IDLE SHALL be ignored.

Reset
REQ-032 On rst=1: state=IDLE, FIFO and tags empty, counters 0; busy, done, wt_ready, px_ready, res_valid, conv_w_en, conv_z_en = 0; conv_w_in, conv_d_in, res_data = 0.
REQ-033 rst mid-job SHALL abort the job with no done pulse; in-flight results are discarded.

Configuration
REQ-034 Macro CONV_FEEDER_RELU_EN defined: values written to the FIFO are max(conv_ans, 0), interpreted as signed.
REQ-035 Macro CONV_FEEDER_RELU_EN undefined: conv_ans is written unmodified.

Verification
REQ-036 25 weights all 1, pixels 1..30 contiguous, res_ready=1 -> 30 results 1,3,6,... then windowed sums (result 30 = 6+7+...+30 = 450); one done pulse.
REQ-037 Same job, res_ready held 0 -> px_ready drops once fifo_count+in_flight=8; release -> all 30 correct, no loss.
REQ-038 num_pix=0 with start -> no weight/pixel accepted, done pulse 1 cycle later, busy stays 0.
REQ-039 rst asserted after 10 of 25 weights -> all outputs at reset values next cycle; new job then completes correctly.
REQ-040 Weights all 1, pixels alternating -5/+5, RELU_EN defined -> no negative result; undefined -> negative results pass through.
REQ-041 wt_valid toggled 0/1 each cycle -> conv_w_en pulses exactly 25 times, STREAM entered after the 25th.
